y86_bus_memory: RTL and testbench

Byte-addressed memory responder for the y86 sequential core's bus: answers the core's 32-bit instruction/data reads combinationally and accepts its 32-bit stores through a one-deep posted write buffer with read forwarding. A loader front end streams the program image in byte by byte before the core is released from reset. Sits in the y86 top level between the core's bus port and the testbench/program source.

---
 rtl/y86_bus_memory.sv | 142 ++++++++++++++
 tb/tb_y86_bus_memory.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/y86_bus_memory.sv
// y86_bus_memory: byte-addressed memory responder for the y86 core bus.
// Combinational 32-bit little-endian reads, one-deep posted write buffer
// with byte-level read forwarding, and a byte-serial loader that holds the
// core in reset until the program image is in.
// Optional: define Y86_BUS_MEMORY_STATS_EN to add rd_count/wr_count outputs.
//
// state | meaning
// LOAD  | loader owns the array, core held in reset, bus ignored
// RUN   | core released, bus reads/writes serviced until rst
module y86_bus_memory #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_A,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              cpu_rst,
  output logic              err
`ifdef Y86_BUS_MEMORY_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [7:0]        mem [DEPTH];

  logic              run;
  logic              in_range;
  logic [ADDR_W-1:0] a;
  logic              ld_fire;
  logic              wr_take;
  logic              rd_take;
  logic              err_set;
  logic [ADDR_W-1:0] byte_addr;
  logic [ADDR_W-1:0] wb_off;

  assign run      = (state == RUN);
  assign in_range = (bus_A[31:ADDR_W] == '0);
  assign a        = bus_A[ADDR_W-1:0];
  assign ld_fire  = ld_valid && ld_ready;
  // A combined RE&WE cycle still performs the write but returns no data.
  assign wr_take  = run && bus_WE && in_range;
  assign rd_take  = run && bus_RE && !bus_WE && in_range;
  assign err_set  = run && (((bus_RE || bus_WE) && !in_range) || (bus_RE && bus_WE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    cpu_rst  = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        cpu_rst  = 1'b1;
        if (ld_valid && (ld_last || ptr == '1)) state_nx = RUN;
      end
      RUN: state_nx = RUN;
      default: state_nx = LOAD;
    endcase
  end

  // Loader pointer, write buffer and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      if (ld_fire) ptr <= ptr + 1'b1;
      wb_valid <= wr_take;
      if (wr_take) begin
        wb_addr <= a;
        wb_data <= bus_wdata;
      end
      if (err_set) err <= 1'b1;
    end
  end

  // Array writes: loader bytes in LOAD, buffer drain (wrapped) in RUN
  always_ff @(posedge clk) begin
    if (ld_fire) mem[ptr] <= ld_data;
    if (wb_valid) begin
      for (int i = 0; i < 4; i++) mem[wb_addr + ADDR_W'(i)] <= wb_data[8*i +: 8];
    end
  end

  // Read mux: each byte wraps independently and prefers a pending buffer byte
  always_comb begin
    bus_rdata = '0;
    byte_addr = '0;
    wb_off    = '0;
    if (rd_take) begin
      for (int i = 0; i < 4; i++) begin
        byte_addr = a + ADDR_W'(i);
        wb_off    = byte_addr - wb_addr;
        if (wb_valid && wb_off < ADDR_W'(4))
          bus_rdata[8*i +: 8] = wb_data[{wb_off[1:0], 3'b000} +: 8];
        else
          bus_rdata[8*i +: 8] = mem[byte_addr];
      end
    end
  end

`ifdef Y86_BUS_MEMORY_STATS_EN
  // Saturating counts of accepted in-range reads and writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_take && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (wr_take && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_bus_memory.sv
// Directed bench for y86_bus_memory: loader, forwarding, wrap, errors, reset.
module tb_y86_bus_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        cpu_rst;
  logic        err;
`ifdef Y86_BUS_MEMORY_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int checks = 0;
  int failures = 0;

  y86_bus_memory #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_rst(cpu_rst), .err(err)
`ifdef Y86_BUS_MEMORY_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
    bus_A     = addr;
    bus_wdata = d;
    bus_WE    = 1'b1;
    tick();
    bus_WE    = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_A = 32'h0; bus_RE = 1'b1; bus_WE = 1'b0; bus_wdata = 32'h0;
    ld_valid = 1'b0; ld_data = 8'h0; ld_last = 1'b0;
    #2;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", bus_rdata); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL load_rdata got=%h exp=00000000", bus_rdata); end
    bus_RE = 1'b0;
  endtask

  // Zero-fill the whole array; the final byte at ptr=DEPTH-1 ends LOAD.
  task automatic test_full_load();
    for (int i = 0; i < 1023; i++) load_byte(8'h00, 1'b0);
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL full_pre_cpu_rst got=%b exp=1", cpu_rst); end
    load_byte(8'h00, 1'b0);
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL full_cpu_rst got=%b exp=0", cpu_rst); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_ld_ready got=%b exp=0", ld_ready); end
  endtask

  task automatic test_reset_mid_load();
    reset_pulse();
    load_byte(8'hA0, 1'b0);
    load_byte(8'hA1, 1'b0);
    load_byte(8'hA2, 1'b0);
    rst = 1'b1;
    #2;
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL mid_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL mid_ld_ready got=%b exp=1", ld_ready); end
`ifdef Y86_BUS_MEMORY_STATS_EN
    checks++; if (rd_count !== 32'h0) begin failures++; $display("FAIL mid_rd_count got=%h exp=0", rd_count); end
    checks++; if (wr_count !== 32'h0) begin failures++; $display("FAIL mid_wr_count got=%h exp=0", wr_count); end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load();
    for (int i = 0; i < 5; i++) load_byte(8'h30 + 8'(i), 1'b0);
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL load_pre_cpu_rst got=%b exp=1", cpu_rst); end
    load_byte(8'h35, 1'b1);
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL load_cpu_rst got=%b exp=0", cpu_rst); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL load_ld_ready got=%b exp=0", ld_ready); end
    // Loader input must be ignored in RUN.
    ld_valid = 1'b1; ld_data = 8'hFF; tick(); ld_valid = 1'b0;
    bus_A = 32'h0; bus_RE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'h33323130) begin failures++; $display("FAIL read_a0 got=%h exp=33323130", bus_rdata); end
    bus_A = 32'h1; #1;
    checks++; if (bus_rdata !== 32'h34333231) begin failures++; $display("FAIL read_a1 got=%h exp=34333231", bus_rdata); end
    bus_A = 32'h5; #1;
    checks++; if (bus_rdata !== 32'h00000035) begin failures++; $display("FAIL read_a5 got=%h exp=00000035", bus_rdata); end
    bus_RE = 1'b0; #1;
    checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL read_re0 got=%h exp=00000000", bus_rdata); end
    tick();
  endtask

  task automatic test_forward();
    bus_write(32'h10, 32'hDEADBEEF);
    bus_A = 32'h0E; bus_RE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'hBEEF0000) begin failures++; $display("FAIL fwd_read got=%h exp=BEEF0000", bus_rdata); end
    tick();
    bus_A = 32'h10; #2;
    checks++; if (bus_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fwd_array got=%h exp=DEADBEEF", bus_rdata); end
    tick();
    bus_RE = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus_write(32'h20, 32'h11111111);
    bus_write(32'h22, 32'h22222222);
    bus_A = 32'h20; bus_RE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'h22221111) begin failures++; $display("FAIL b2b_fwd got=%h exp=22221111", bus_rdata); end
    tick();
    bus_A = 32'h22; #2;
    checks++; if (bus_rdata !== 32'h22222222) begin failures++; $display("FAIL b2b_a22 got=%h exp=22222222", bus_rdata); end
    bus_A = 32'h24; #1;
    checks++; if (bus_rdata !== 32'h00002222) begin failures++; $display("FAIL b2b_a24 got=%h exp=00002222", bus_rdata); end
    bus_A = 32'h20; #1;
    checks++; if (bus_rdata !== 32'h22221111) begin failures++; $display("FAIL b2b_array got=%h exp=22221111", bus_rdata); end
    tick();
    bus_RE = 1'b0;
  endtask

  task automatic test_wrap();
    bus_write(32'h3FE, 32'hAABBCCDD);
    bus_A = 32'h3FE; bus_RE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'hAABBCCDD) begin failures++; $display("FAIL wrap_fwd got=%h exp=AABBCCDD", bus_rdata); end
    tick();
    bus_A = 32'h000; #2;
    checks++; if (bus_rdata !== 32'h3332AABB) begin failures++; $display("FAIL wrap_a0 got=%h exp=3332AABB", bus_rdata); end
    bus_A = 32'h3FE; #1;
    checks++; if (bus_rdata !== 32'hAABBCCDD) begin failures++; $display("FAIL wrap_array got=%h exp=AABBCCDD", bus_rdata); end
    tick();
    bus_RE = 1'b0;
  endtask

  task automatic test_err();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b exp=0", err); end
    bus_A = 32'h400; bus_RE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL err_range_rdata got=%h exp=00000000", bus_rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err); end
    tick();
    bus_RE = 1'b0; #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_range got=%b exp=1", err); end
    bus_write(32'h410, 32'h55555555);
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    bus_A = 32'h10; bus_RE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL err_wr_dropped got=%h exp=DEADBEEF", bus_rdata); end
    tick();
    bus_RE = 1'b0;

    reset_pulse();
    load_byte(8'h77, 1'b1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", err); end
    bus_A = 32'h40; bus_wdata = 32'h12345678; bus_RE = 1'b1; bus_WE = 1'b1; #2;
    checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL rewe_rdata got=%h exp=00000000", bus_rdata); end
    tick();
    bus_RE = 1'b0; bus_WE = 1'b0; #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL rewe_err got=%b exp=1", err); end
    bus_A = 32'h40; bus_RE = 1'b1; #1;
    checks++; if (bus_rdata !== 32'h12345678) begin failures++; $display("FAIL rewe_write got=%h exp=12345678", bus_rdata); end
    tick();
    bus_RE = 1'b0;
`ifdef Y86_BUS_MEMORY_STATS_EN
    checks++; if (rd_count !== 32'd1) begin failures++; $display("FAIL stats_rd got=%0d exp=1", rd_count); end
    checks++; if (wr_count !== 32'd1) begin failures++; $display("FAIL stats_wr got=%0d exp=1", wr_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reset_mid_load();
    test_load();
    test_forward();
    test_back_to_back();
    test_wrap();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
